// File: rtl/ps2_kbd_port_if.sv
// CPU-side I/O bus of the PS/2 keyboard port: read strobe, register select, read data, interrupt.
// Latency: rd_data is combinational from the strobe and select; intr/ready are registered state.
// Backpressure: none; every strobed read is served in the same cycle.
interface ps2_kbd_port_if;
    logic        io_rdn;
    logic        io_addr;
    logic [31:0] rd_data;
    logic        intr;
    logic        ready;

    modport master (output io_rdn, output io_addr, input rd_data, input intr, input ready);
    modport slave  (input io_rdn, input io_addr, output rd_data, output intr, output ready);
endinterface

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard receiver: deserializes 11-bit frames, queues scan codes, raises intr while any are queued.
// Latency: pin edge seen 3-4 cycles later; code visible on the edge after the 11th bit is detected.
// Backpressure: none toward the device; a frame arriving to a full queue is dropped and flagged overflow.
module ps2_kbd_port #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 5000
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_kbd_port_if.slave  bus
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [2:0]            ps2c_q, ps2d_q;
    logic [3:0]            bitcnt_q, bitcnt_d;
    logic [10:0]           shreg_q, shreg_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, ferr_q, ferr_d;
    logic [7:0]            mem_q [DEPTH];

    logic        fall, frame_done, frame_ok;
    logic        empty, full, data_rd, stat_rd, push, pop;
    logic [10:0] frame;

    // Bits enter at the top so that after 11 shifts bit 0 holds the start bit.
    assign fall     = ps2c_q[2] & ~ps2c_q[1];
    assign frame    = {ps2d_q[1], shreg_q[10:1]};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
    assign data_rd = ~bus.io_rdn & ~bus.io_addr;
    assign stat_rd = ~bus.io_rdn &  bus.io_addr;
    assign pop     = data_rd & ~empty;
    assign push    = frame_done & frame_ok & (~full | pop);

    // Bit counter, shift register and mid-frame idle timeout.
    always_comb begin
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        idle_d     = idle_q;
        frame_done = 1'b0;
        if (fall) begin
            shreg_d = frame;
            idle_d  = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d   = 4'd0;
                frame_done = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                bitcnt_d = 4'd0;
                idle_d   = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Queue occupancy and sticky error flags; a new error in a status-read cycle wins over the clear.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d  = (frame_done & frame_ok & full & ~pop) | (ovf_q & ~stat_rd);
        ferr_d = (frame_done & ~frame_ok) | (ferr_q & ~stat_rd);
    end

    // Synchronizers idle high; all control state clears on reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ps2c_q   <= 3'b111;
            ps2d_q   <= 3'b111;
            bitcnt_q <= 4'd0;
            shreg_q  <= '0;
            idle_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            ps2c_q   <= {ps2c_q[1:0], ps2_clk};
            ps2d_q   <= {ps2d_q[1:0], ps2_data};
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            idle_q   <= idle_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Queue storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= frame[8:1];
    end

    // Read mux: data head, status word, or zero when not strobed or the queue is empty.
    always_comb begin
        bus.rd_data = 32'd0;
        if (data_rd && !empty) begin
            bus.rd_data = {24'd0, mem_q[rd_ptr_q]};
        end else if (stat_rd) begin
            bus.rd_data = {24'd0, 5'(cnt_q), ferr_q, ovf_q, ~empty};
        end
    end

    assign bus.ready = ~empty;
    assign bus.intr  = ~empty;
endmodule
